// File: rtl/qdiv_pkg.sv
// Shared types, widths and arithmetic helpers for the quaternion divider.
package qdiv_pkg;

  localparam int OPW   = 16;  // operand component width
  localparam int NUMW  = 34;  // signed numerator width
  localparam int NORMW = 33;  // unsigned divisor norm width
  localparam int RESW  = 32;  // signed quotient width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Full-precision signed product of two operand components.
  function automatic logic signed [NUMW-1:0] prod(input logic signed [OPW-1:0] x,
                                                   input logic signed [OPW-1:0] y);
    logic signed [NUMW-1:0] xe;
    logic signed [NUMW-1:0] ye;
    xe = NUMW'(x);
    ye = NUMW'(y);
    return xe * ye;
  endfunction

  // Square of an operand component; the magnitude of -32768 still fits 16 unsigned bits.
  function automatic logic [NORMW-1:0] sq(input logic signed [OPW-1:0] x);
    logic [OPW-1:0] ux;
    ux = x[OPW-1] ? -x : x;
    return NORMW'(ux) * NORMW'(ux);
  endfunction

endpackage

// File: rtl/qdiv_serial_core.sv
// Restoring unsigned divider producing one quotient bit per clock.
// A start pulse loads the dividend and performs the first step in the same
// cycle, so exactly NB cycles elapse from start to the cycle flagging done.
// quotient/remainder are valid in the cycle where done is high.
module qdiv_serial_core
  import qdiv_pkg::*;
#(
  parameter int NB = 42
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NB-1:0]    magnitude,
  input  logic [NORMW-1:0] divisor,
  output logic [NB-1:0]    quotient,
  output logic [NORMW-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(NB + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [NORMW-1:0] r_rem;
  logic [NB-1:0]    r_dvd;
  logic [NB-1:0]    r_quo;

  logic [NORMW-1:0] w_rem_in;
  logic [NB-1:0]    w_dvd_in;
  logic [NB-1:0]    w_quo_in;
  logic [NORMW:0]   w_trial;
  logic             w_ge;
  logic [NORMW-1:0] w_rem_nx;
  logic [NB-1:0]    w_quo_nx;
  logic [NB-1:0]    w_dvd_nx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    // NOTE: every signal gets a value on every path of a combinational block, otherwise a latch is inferred.
    w_rem_in = start ? '0 : r_rem;
    w_dvd_in = start ? magnitude : r_dvd;
    w_quo_in = start ? '0 : r_quo;
    w_trial  = {w_rem_in, w_dvd_in[NB-1]};
    w_ge     = (w_trial >= {1'b0, divisor});
    w_rem_nx = w_ge ? (w_trial[NORMW-1:0] - divisor) : w_trial[NORMW-1:0];
    w_quo_nx = (w_quo_in << 1) | NB'(w_ge);
    w_dvd_nx = w_dvd_in << 1;
  end

  assign quotient  = w_quo_nx;
  assign remainder = w_rem_nx;
  assign done      = r_busy && (r_cnt == CW'(1));

  // Step registers and remaining-step counter.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(NB - 1);
      r_rem  <= w_rem_nx;
      r_dvd  <= w_dvd_nx;
      r_quo  <= w_quo_nx;
    end else if (r_busy) begin
      r_cnt  <= r_cnt - CW'(1);
      r_rem  <= w_rem_nx;
      r_dvd  <= w_dvd_nx;
      r_quo  <= w_quo_nx;
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/quaternion_divider.sv
// Quaternion divider: c = a * conj(b) / |b|^2, scaled by 2^FRAC_BITS.
// Numerators and norm are formed at full precision in one cycle, then a single
// serial divider is time-shared over the four components (0,1,2,3).
// Build option: define QDIV_ROUND_EN to round each quotient half away from
// zero instead of truncating toward zero.
module quaternion_divider
  import qdiv_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [OPW-1:0]  a0,
  input  logic signed [OPW-1:0]  a1,
  input  logic signed [OPW-1:0]  a2,
  input  logic signed [OPW-1:0]  a3,
  input  logic signed [OPW-1:0]  b0,
  input  logic signed [OPW-1:0]  b1,
  input  logic signed [OPW-1:0]  b2,
  input  logic signed [OPW-1:0]  b3,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [RESW-1:0] c0,
  output logic signed [RESW-1:0] c1,
  output logic signed [RESW-1:0] c2,
  output logic signed [RESW-1:0] c3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   div_by_zero
);

  localparam int NB = NUMW + FRAC_BITS;

`ifdef QDIV_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  state_t r_state;
  state_t w_state_nx;

  logic signed [OPW-1:0]  r_a [4];
  logic signed [OPW-1:0]  r_b [4];
  logic signed [NUMW-1:0] r_n [4];
  logic [NORMW-1:0]       r_norm;
  logic signed [RESW-1:0] r_part [3];
  logic signed [RESW-1:0] r_c [4];
  logic [1:0]             r_idx;
  logic                   r_need_start;
  logic                   r_dbz;

  logic signed [NUMW-1:0] w_n [4];
  logic [NORMW-1:0]       w_norm;
  logic signed [NUMW-1:0] w_nsel;
  logic [NUMW-1:0]        w_nmag;
  logic [NB-1:0]          w_mag;
  logic                   w_start;
  logic [NB-1:0]          w_quo;
  logic [NORMW-1:0]       w_rem;
  logic                   w_core_done;
  logic                   w_round_up;
  logic [NB-1:0]          w_qmag;
  logic [NB-1:0]          w_res_wide;
  logic signed [RESW-1:0] w_res;

  // Numerators of a * conj(b) and the divisor norm from the held operands.
  always_comb begin
    w_n[0] =  prod(r_a[0], r_b[0]) + prod(r_a[1], r_b[1])
            + prod(r_a[2], r_b[2]) + prod(r_a[3], r_b[3]);
    w_n[1] = -prod(r_a[0], r_b[1]) + prod(r_a[1], r_b[0])
            - prod(r_a[2], r_b[3]) + prod(r_a[3], r_b[2]);
    w_n[2] = -prod(r_a[0], r_b[2]) + prod(r_a[1], r_b[3])
            + prod(r_a[2], r_b[0]) - prod(r_a[3], r_b[1]);
    w_n[3] = -prod(r_a[0], r_b[3]) - prod(r_a[1], r_b[2])
            + prod(r_a[2], r_b[1]) + prod(r_a[3], r_b[0]);
    w_norm = sq(r_b[0]) + sq(r_b[1]) + sq(r_b[2]) + sq(r_b[3]);
  end

  // Divider operand selection and sign/rounding of the finished component.
  always_comb begin
    w_nsel     = r_n[r_idx];
    w_nmag     = w_nsel[NUMW-1] ? -w_nsel : w_nsel;
    w_mag      = NB'(w_nmag) << FRAC_BITS;
    w_start    = (r_state == DIV) && r_need_start;
    w_round_up = ({w_rem, 1'b0} >= {1'b0, r_norm});
    w_qmag     = w_quo + NB'(ROUND_EN && w_round_up);
    w_res_wide = w_nsel[NUMW-1] ? -w_qmag : w_qmag;
    w_res      = RESW'(w_res_wide);
  end

  qdiv_serial_core #(
    .NB (NB)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .magnitude (w_mag),
    .divisor   (r_norm),
    .quotient  (w_quo),
    .remainder (w_rem),
    .done      (w_core_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = PREP;
      end
      PREP: w_state_nx = (w_norm == '0) ? DONE : DIV;
      DIV:  if (w_core_done && (r_idx == 2'd3)) w_state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Operand capture, numerator staging and per-component result collection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: these arrays are small flop banks, not RAM, so clearing them in reset is legitimate.
      r_a          <= '{default: '0};
      r_b          <= '{default: '0};
      r_n          <= '{default: '0};
      r_part       <= '{default: '0};
      r_c          <= '{default: '0};
      r_norm       <= '0;
      r_idx        <= '0;
      r_need_start <= 1'b0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= '{a0, a1, a2, a3};
            r_b <= '{b0, b1, b2, b3};
          end
        end
        PREP: begin
          r_n          <= w_n;
          r_norm       <= w_norm;
          r_idx        <= '0;
          r_need_start <= (w_norm != '0);
          if (w_norm == '0) begin
            r_c   <= '{default: '0};
            r_dbz <= 1'b1;
          end
        end
        DIV: begin
          if (w_start) r_need_start <= 1'b0;
          if (w_core_done) begin
            if (r_idx == 2'd3) begin
              r_c   <= '{r_part[0], r_part[1], r_part[2], w_res};
              r_dbz <= 1'b0;
            end else begin
              r_part       <= '{r_part[1], r_part[2], w_res};
              r_idx        <= r_idx + 2'd1;
              r_need_start <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign c0          = r_c[0];
  assign c1          = r_c[1];
  assign c2          = r_c[2];
  assign c3          = r_c[3];
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_quaternion_divider.sv
// Scoreboard bench for quaternion_divider (FRAC_BITS = 8).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares whenever out_valid is presented.
module tb_quaternion_divider;

  localparam int FB    = 8;
  localparam int LAT_N = 1 + 4 * (34 + FB);
  localparam int LAT_Z = 1;
`ifdef QDIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, div_by_zero;
  logic signed [31:0] c0, c1, c2, c3;

  always #5 clk = ~clk;

  quaternion_divider #(.FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_valid(in_valid), .in_ready(in_ready),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .out_valid(out_valid), .out_ready(out_ready), .div_by_zero(div_by_zero)
  );

  typedef struct {
    int    e [4];
    bit    dbz;
    int    lat;
    int    acc;
    string tag;
  } exp_t;

  exp_t sb [$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation; called just after a clock edge.
  task automatic issue(input string tag, input bit push,
                       input int x0, input int x1, input int x2, input int x3,
                       input int y0, input int y1, input int y2, input int y3,
                       input int e0, input int e1, input int e2, input int e3,
                       input bit dbz, input int lat);
    exp_t t;
    int   n = 0;
    a0 = 16'(x0); a1 = 16'(x1); a2 = 16'(x2); a3 = 16'(x3);
    b0 = 16'(y0); b1 = 16'(y1); b2 = 16'(y2); b3 = 16'(y3);
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      step();
      n++;
    end
    check({tag, " accept"}, 64'(in_ready), 64'(1));
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
    t.e   = '{e0, e1, e2, e3};
    t.dbz = dbz;
    t.lat = lat;
    t.acc = cyc;
    t.tag = tag;
    if (push) sb.push_back(t);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mon_active) && n < 2000) begin
      step();
      n++;
    end
    check("drain", 64'(sb.size() == 0 && !mon_active), 64'(1));
  endtask

  // Monitor: pop on first presentation, then compare every cycle out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (out_valid) begin
      if (!mon_active) begin
        if (sb.size() == 0) begin
          check("unexpected out_valid", 64'(1), 64'(0));
        end else begin
          cur = sb.pop_front();
          mon_active = 1'b1;
          check({cur.tag, " latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end
      if (mon_active) begin
        check({cur.tag, " c0"}, c0, 64'(cur.e[0]));
        check({cur.tag, " c1"}, c1, 64'(cur.e[1]));
        check({cur.tag, " c2"}, c2, 64'(cur.e[2]));
        check({cur.tag, " c3"}, c3, 64'(cur.e[3]));
        check({cur.tag, " div_by_zero"}, 64'(div_by_zero), 64'(cur.dbz));
        check({cur.tag, " in_ready busy"}, 64'(in_ready), 64'(0));
        if (out_ready) mon_active = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit any_valid;
    int n;
    {a0, a1, a2, a3, b0, b1, b2, b3} = '0;
    repeat (3) step();
    rst_n = 1'b1;

    check("reset in_ready", 64'(in_ready), 64'(1));
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset div_by_zero", 64'(div_by_zero), 64'(0));
    check("reset c0", c0, 64'(0));
    check("reset c3", c3, 64'(0));

    // Directed vectors, back to back with the consumer always ready.
    issue("real2", 1, 2, 0, 0, 0, 1, 0, 0, 0, 512, 0, 0, 0, 0, LAT_N);
    issue("i_by_i", 1, 0, 1, 0, 0, 0, 1, 0, 0, 256, 0, 0, 0, 0, LAT_N);
    issue("2_by_3", 1, 2, 0, 0, 0, 3, 0, 0, 0, RND ? 171 : 170, 0, 0, 0, 0, LAT_N);
    issue("m2_by_3", 1, -2, 0, 0, 0, 3, 0, 0, 0, RND ? -171 : -170, 0, 0, 0, 0, LAT_N);
    issue("zero_div", 1, 5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1, LAT_Z);
    issue("self", 1, 1, 2, 3, 4, 1, 2, 3, 4, 256, 0, 0, 0, 0, LAT_N);
    issue("j_by_i", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 256, 0, LAT_N);
    issue("mixed", 1, 3, 5, -7, 2, 0, 0, 0, -3,
          RND ? -171 : -170, -597, RND ? -427 : -426, 256, 0, LAT_N);
    issue("extreme", 1, -32768, 32767, -32768, 32767, 1, 0, 0, 0,
          -8388608, 8388352, -8388608, 8388352, 0, LAT_N);
    issue("min_div", 1, -32768, -32768, -32768, -32768, -32768, 0, 0, 0,
          256, 256, 256, 256, 0, LAT_N);
    drain();

    // Consumer stalls in DONE for 10 cycles, then a second op follows at once.
    out_ready = 1'b0;
    issue("hold", 1, 2, 0, 0, 0, 3, 0, 0, 0, RND ? 171 : 170, 0, 0, 0, 0, LAT_N);
    n = 0;
    while (!out_valid && n < 400) begin
      step();
      n++;
    end
    check("hold out_valid", 64'(out_valid), 64'(1));
    repeat (10) step();
    out_ready = 1'b1;
    step();
    check("in_ready after release", 64'(in_ready), 64'(1));
    issue("after_hold", 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 256, 0, LAT_N);
    drain();

    // Reset in the middle of a divide abandons the operation.
    issue("aborted", 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, LAT_N);
    repeat (50) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("post-reset in_ready", 64'(in_ready), 64'(1));
    check("post-reset c3", c3, 64'(0));
    any_valid = 1'b0;
    repeat (200) begin
      step();
      if (out_valid) any_valid = 1'b1;
    end
    check("no result after abort", 64'(any_valid), 64'(0));
    issue("after_reset", 1, 1, 0, 0, 0, 1, 0, 0, 0, 256, 0, 0, 0, 0, LAT_N);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
